// File: rtl/fpu_pkg.sv
// Shared FPU datapath constants for the mantissa multiplier.
package fpu_pkg;

  localparam int MAN_WIDTH  = 24;
  localparam int PROD_WIDTH = 2 * MAN_WIDTH;

endpackage : fpu_pkg

// File: rtl/braun_fa_cell.sv
// One-bit full adder: the basic cell of the Braun carry-save array.
module braun_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic half_sum;

  assign half_sum = a ^ b;
  assign sum      = half_sum ^ cin;
  assign cout     = (a & b) | (cin & half_sum);

endmodule : braun_fa_cell

// File: rtl/braun_multiplication.sv
// Unsigned Braun array mantissa multiplier with a registered, normalized and
// truncated upper mantissa plus an overflow flag for exponent adjustment.
module braun_multiplication
  import fpu_pkg::*;
#(
  parameter int BIT_LENGTH = MAN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIT_LENGTH-1:0] man_x,
  input  logic [BIT_LENGTH-1:0] man_y,
  output logic [BIT_LENGTH-1:0] result,
  output logic                  redundant_mul
);

  localparam int N = BIT_LENGTH;

  logic [2*N-1:0] prod;
  logic [2*N-1:0] check;
  logic           unused_final_cout;

  // Row gi, column gj carries weight gi+gj in its sum and gi+gj+1 in its carry.
  // Row 0 is the bare partial products; each later row folds in one more
  // partial-product row while keeping carries unresolved (carry-save).
  for (genvar gi = 0; gi < N; gi++) begin : gen_row
    for (genvar gj = 0; gj < N; gj++) begin : gen_col
      logic s;
      logic c;
      logic pp;

      assign pp = man_x[gj] & man_y[gi];

      if (gi == 0) begin : gen_first
        assign s = pp;
        assign c = 1'b0;
      end else begin : gen_csa
        logic b_in;

        // The row's top cell has no previous-row sum at its weight, only the carry.
        if (gj == N - 1) begin : gen_top
          assign b_in = 1'b0;
        end else begin : gen_mid
          assign b_in = gen_row[gi-1].gen_col[gj+1].s;
        end

        braun_fa_cell u_fa (
          .a    (pp),
          .b    (b_in),
          .cin  (gen_row[gi-1].gen_col[gj].c),
          .sum  (s),
          .cout (c)
        );
      end
    end

    // Column 0 of each row is final once the row is formed.
    assign prod[gi] = gen_row[gi].gen_col[0].s;
  end

  // Final ripple row resolves the last row's sums and carries into the upper half.
  for (genvar gj = 0; gj < N; gj++) begin : gen_rip
    logic b_in;
    logic cin;
    logic sum;
    logic cout;

    if (gj == N - 1) begin : gen_top
      assign b_in = 1'b0;
    end else begin : gen_mid
      assign b_in = gen_row[N-1].gen_col[gj+1].s;
    end

    if (gj == 0) begin : gen_lsb
      assign cin = 1'b0;
    end else begin : gen_chain
      assign cin = gen_rip[gj-1].cout;
    end

    braun_fa_cell u_fa (
      .a    (gen_row[N-1].gen_col[gj].c),
      .b    (b_in),
      .cin  (cin),
      .sum  (sum),
      .cout (cout)
    );

    assign prod[N+gj] = sum;
  end

  // An N x N product always fits in 2N bits, so this carry is structurally zero.
  assign unused_final_cout = gen_rip[N-1].cout;

  always_ff @(posedge clk) begin
    if (rst) begin
      check         <= '0;
      result        <= '0;
      redundant_mul <= 1'b0;
    end else begin
      check         <= prod;
      redundant_mul <= prod[2*N-1];
      if (prod[2*N-1]) begin
        result <= prod[2*N-1:N];
      end else begin
        result <= prod[2*N-2:N-1];
      end
    end
  end

endmodule : braun_multiplication

// File: tb/tb_braun_multiplication.sv
// Directed and random checks of braun_multiplication against a plain-arithmetic model.
module tb_braun_multiplication;

  localparam int N = 24;

  logic         clk;
  logic         rst;
  logic [N-1:0] man_x;
  logic [N-1:0] man_y;
  logic [N-1:0] result;
  logic         redundant_mul;

  int n_cmp;
  int n_bad;

  logic [2*N-1:0] exp_check;
  logic [N-1:0]   exp_result;
  logic           exp_red;
  logic           model_valid;

  braun_multiplication #(.BIT_LENGTH(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .man_x         (man_x),
    .man_y         (man_y),
    .result        (result),
    .redundant_mul (redundant_mul)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Model: registered full product, normalized by shifting on the product MSB.
  always @(posedge clk) begin
    logic [2*N-1:0] p;
    logic [2*N-1:0] shifted;
    p = {{N{1'b0}}, man_x} * {{N{1'b0}}, man_y};
    shifted = p[2*N-1] ? (p >> N) : (p >> (N - 1));
    model_valid <= 1'b1;
    if (rst) begin
      exp_check  <= '0;
      exp_result <= '0;
      exp_red    <= 1'b0;
    end else begin
      exp_check  <= p;
      exp_result <= shifted[N-1:0];
      exp_red    <= p[2*N-1];
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      chk("model_check", 64'(dut.check), 64'(exp_check));
      chk("model_result", 64'(result), 64'(exp_result));
      chk("model_red", 64'(redundant_mul), 64'(exp_red));
    end
  end

  // Drive at a negedge, let one rising edge pass, then check literals.
  task automatic apply(input string name, input logic [N-1:0] x, input logic [N-1:0] y,
                       input logic [2*N-1:0] c, input logic [N-1:0] r, input logic red);
    man_x = x;
    man_y = y;
    @(negedge clk);
    $display("txn %s: x=%06h y=%06h check=%012h result=%06h red=%0b",
             name, x, y, dut.check, result, redundant_mul);
    chk({name, "_check"}, 64'(dut.check), 64'(c));
    chk({name, "_result"}, 64'(result), 64'(r));
    chk({name, "_red"}, 64'(redundant_mul), 64'(red));
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    model_valid = 1'b0;
    rst         = 1'b1;
    man_x       = 24'hFFFFFF;
    man_y       = 24'hFFFFFF;
    repeat (3) @(negedge clk);
    chk("reset_check", 64'(dut.check), 64'h0);
    chk("reset_result", 64'(result), 64'h0);
    chk("reset_red", 64'(redundant_mul), 64'h0);

    rst = 1'b0;
    apply("max", 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 24'hFFFFFE, 1'b1);
    apply("half_x", 24'h800000, 24'h580000, 48'h2C0000000000, 24'h580000, 1'b0);
    apply("mixed", 24'h940000, 24'h000410, 48'h000259400000, 24'h0004B2, 1'b0);
    apply("s5x6", 24'd5, 24'd6, 48'h1E, 24'h0, 1'b0);
    apply("s6x5", 24'd6, 24'd5, 48'h1E, 24'h0, 1'b0);
    apply("s16x15", 24'd16, 24'd15, 48'hF0, 24'h0, 1'b0);
    apply("zero", 24'h000000, 24'hABCDEF, 48'h0, 24'h0, 1'b0);
    apply("ident", 24'h800000, 24'h800000, 48'h400000000000, 24'h800000, 1'b0);
    rst = 1'b1;
    apply("rst_mid", 24'hFFFFFF, 24'hFFFFFF, 48'h0, 24'h0, 1'b0);
    rst = 1'b0;
    apply("after_rst", 24'hC00000, 24'hC00000, 48'h900000000000, 24'h900000, 1'b1);

    for (int i = 0; i < 10000; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      man_x = N'($urandom);
      man_y = N'($urandom);
      if ($urandom_range(0, 15) == 0) man_x = man_x | 24'h800000;
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_braun_multiplication

// File: doc/braun_multiplication.md
Name: braun_multiplication

Overview:
- Unsigned BIT_LENGTH x BIT_LENGTH mantissa multiplier for the single-precision FPU multiply datapath.
- Implemented as a Braun carry-save array: AND partial products, rows of full adders, and a final ripple row.
- Produces the normalized upper mantissa (truncated) plus a mantissa-overflow flag (product >= 2.0) for exponent adjustment.
- Output is registered: one clock, synchronous active-high reset.

Parameters:
- BIT_LENGTH, 24, operand width. Each operand is a mantissa including the hidden bit; product width is 2*BIT_LENGTH.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  synchronous active-high reset
- man_x  input  BIT_LENGTH  multiplicand mantissa (unsigned, hidden bit at MSB)
- man_y  input  BIT_LENGTH  multiplier mantissa (unsigned, hidden bit at MSB)
- result  output  BIT_LENGTH  normalized truncated product mantissa
- redundant_mul  output  1  product MSB set; the exponent must be incremented by 1

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Combinational core: P = man_x * man_y, full 2*BIT_LENGTH-bit unsigned product.
  - Partial products: pp[i][j] = man_x[j] & man_y[i].
  - Array: BIT_LENGTH-1 carry-save rows of full adders, then a ripple-carry final row.
  - No Booth recoding; no signed handling.
- Internal registered signal named check (2*BIT_LENGTH bits) holds P. It must keep this exact name because benches probe DUT.check hierarchically. It is not a port.
- Normalization:
  - redundant_mul = P[2N-1], where N = BIT_LENGTH.
  - If P[2N-1] = 1: result = P[2N-1:N].
  - Else: result = P[2N-2:N-1].
  - Lower bits are truncated: no rounding, no sticky/guard outputs.
- Latency: 1 cycle. Operands present before rising edge k appear on result, redundant_mul and check after edge k. There is no handshake; a new operand pair is accepted every cycle (throughput 1/cycle).
- Reset: on a rising edge with rst = 1, result = 0, redundant_mul = 0, check = 0, regardless of inputs. Reset dominates any simultaneous new operands. Reset asserted mid-stream discards the in-flight product. The first valid output follows the first edge with rst = 0.
- Boundary cases:
  - A zero operand gives all outputs 0.
  - Non-normalized (small) operands are not renormalized: result is simply the selected slice and may be 0 while check is non-zero.
  - The maximum case, all-ones x all-ones, must not overflow: P fits exactly in 2N bits.
- All logic is synthesizable. There are no latches. Outputs change only on clk.

Decomposition:
- Shared package fpu_pkg:
  - constant MAN_WIDTH = 24 (the BIT_LENGTH default source)
  - constant PROD_WIDTH = 2*MAN_WIDTH
- One sub-module, braun_fa_cell: a 1-bit full adder (a, b, cin -> sum, cout). It is instantiated in generate loops for the carry-save rows and the final ripple row.
- The alternative Vedic_Multiplication implementation must have an identical port list and behaviour. It is selected by the SECOND_ALGORITHM define.

Test Plan:
- Reset: hold rst = 1 with man_x = 0xFFFFFF, man_y = 0xFFFFFF -> result = 0, redundant_mul = 0, check = 0. Release rst -> the next edge gives check = 0xFFFFFE000001, result = 0xFFFFFE, redundant_mul = 1.
- man_x = 0x800000, man_y = 0x580000 -> check = 0x2C0000000000, result = 0x580000, redundant_mul = 0.
- man_x = 0x940000, man_y = 0x000410 -> check = 0x000259400000, result = 0x0004B2, redundant_mul = 0.
- Small operands, back-to-back each cycle:
  - 5x6 -> check = 0x1E.
  - 6x5 -> check = 0x1E (commutativity).
  - 16x15 -> check = 0xF0.
  - For all three, result = 0 and redundant_mul = 0, with one-cycle latency and no bubbles.
- Zero and identity:
  - 0x000000 x 0xABCDEF -> all outputs 0.
  - 0x800000 x 0x800000 -> check = 0x400000000000, result = 0x800000, redundant_mul = 0.
- Random: 10k random pairs compared against a reference model (check == x*y; result and redundant_mul per the normalization rule), including rst pulses injected mid-stream.
